// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//
// Registered branch resolution stage for the 32-bit datapath. Accepts one branch per cycle
// and resolves beq/bne/bgt/ble/jump from the ALU compare flags. Computes the sign-extended,
// word-shifted target. Returns the next PC through a valid/ready output register.
// Keeps a per-index 2-bit saturating prediction table (PHT) and two saturating statistics
// counters. Flags mispredicted conditional branches.
//
// Ports:
//   clk, reset        clock; synchronous active-low reset
//   in_valid/in_ready input handshake (in_ready = !out_valid || out_ready)
//   branch_op         000 beq, 001 bne, 010 bgt, 011 ble, 100 jump, others illegal
//   pc_plus4, offset  branch PC + 4 and signed word offset
//   gt, lt, et        ALU compare flags
//   flush             drops the pending result and any same-cycle input
//   out_valid/out_ready, next_pc, taken, mispredict, illegal   registered result
//   br_count, mp_count  accepted / mispredicted conditional branches, saturating
module branch_resolve_unit #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned OFFSET_W  = 16,
  parameter int unsigned PHT_IDX_W = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          branch_op,
  input  logic [DATA_W-1:0]   pc_plus4,
  input  logic [OFFSET_W-1:0] offset,
  input  logic                gt,
  input  logic                lt,
  input  logic                et,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   next_pc,
  output logic                taken,
  output logic                mispredict,
  output logic                illegal,
  output logic [CNT_W-1:0]    br_count,
  output logic [CNT_W-1:0]    mp_count
);

  localparam int unsigned PhtEntries = 1 << PHT_IDX_W;

  localparam logic [2:0] OpBeq  = 3'b000;
  localparam logic [2:0] OpBne  = 3'b001;
  localparam logic [2:0] OpBgt  = 3'b010;
  localparam logic [2:0] OpBle  = 3'b011;
  localparam logic [2:0] OpJump = 3'b100;

  // State
  logic                          out_valid_q, out_valid_d;
  logic [DATA_W-1:0]             next_pc_q, next_pc_d;
  logic                          taken_q, taken_d;
  logic                          mispredict_q, mispredict_d;
  logic                          illegal_q, illegal_d;
  logic [CNT_W-1:0]              br_count_q, br_count_d;
  logic [CNT_W-1:0]              mp_count_q, mp_count_d;
  logic [PhtEntries-1:0][1:0]    pht_q, pht_d;

  // Decode / resolve
  logic                  accept;
  logic                  is_cond;
  logic                  cond_taken;
  logic                  op_illegal;
  logic [DATA_W-1:0]     off_ext;
  logic [DATA_W-1:0]     target;
  logic [PHT_IDX_W-1:0]  pht_idx;
  logic [1:0]            pht_cur;
  logic                  predict;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign is_cond  = (branch_op[2] == 1'b0);

  always_comb begin
    cond_taken = 1'b0;
    op_illegal = 1'b0;
    unique case (branch_op)
      OpBeq:   cond_taken = et;
      OpBne:   cond_taken = !et;
      OpBgt:   cond_taken = gt;
      OpBle:   cond_taken = lt | et;
      OpJump:  cond_taken = 1'b1;
      default: op_illegal = 1'b1;
    endcase
  end

  // Offset is in words: sign-extend to full width, then scale by 4. Sum wraps modulo 2^DATA_W.
  assign off_ext = {{(DATA_W-OFFSET_W){offset[OFFSET_W-1]}}, offset};
  assign target  = pc_plus4 + (off_ext << 2);

  assign pht_idx = pc_plus4[PHT_IDX_W+1:2];
  assign pht_cur = pht_q[pht_idx];
  assign predict = pht_cur[1];

  // PHT and statistics only move for accepted conditional branches.
  always_comb begin
    pht_d      = pht_q;
    br_count_d = br_count_q;
    mp_count_d = mp_count_q;
    if (accept && is_cond) begin
      if (cond_taken) begin
        if (pht_cur != 2'd3) pht_d[pht_idx] = pht_cur + 2'd1;
      end else begin
        if (pht_cur != 2'd0) pht_d[pht_idx] = pht_cur - 2'd1;
      end
      if (br_count_q != {CNT_W{1'b1}}) br_count_d = br_count_q + CNT_W'(1);
      if ((predict != cond_taken) && (mp_count_q != {CNT_W{1'b1}})) begin
        mp_count_d = mp_count_q + CNT_W'(1);
      end
    end
  end

  // Result register: flush kills, accept loads (also on a same-cycle drain), drain clears.
  always_comb begin
    out_valid_d  = out_valid_q;
    next_pc_d    = next_pc_q;
    taken_d      = taken_q;
    mispredict_d = mispredict_q;
    illegal_d    = illegal_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d  = 1'b1;
      taken_d      = cond_taken;
      next_pc_d    = cond_taken ? target : pc_plus4;
      mispredict_d = is_cond && (predict != cond_taken);
      illegal_d    = op_illegal;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_q  <= 1'b0;
      next_pc_q    <= '0;
      taken_q      <= 1'b0;
      mispredict_q <= 1'b0;
      illegal_q    <= 1'b0;
      br_count_q   <= '0;
      mp_count_q   <= '0;
      for (int i = 0; i < PhtEntries; i++) pht_q[i] <= 2'b01;
    end else begin
      out_valid_q  <= out_valid_d;
      next_pc_q    <= next_pc_d;
      taken_q      <= taken_d;
      mispredict_q <= mispredict_d;
      illegal_q    <= illegal_d;
      br_count_q   <= br_count_d;
      mp_count_q   <= mp_count_d;
      pht_q        <= pht_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign next_pc    = next_pc_q;
  assign taken      = taken_q;
  assign mispredict = mispredict_q;
  assign illegal    = illegal_q;
  assign br_count   = br_count_q;
  assign mp_count   = mp_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: table-driven vectors plus hand-written
// sequences for backpressure, flush and mid-stream reset.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  branch_op;
  logic [31:0] pc_plus4;
  logic [15:0] offset;
  logic        gt, lt, et;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] next_pc;
  logic        taken;
  logic        mispredict;
  logic        illegal;
  logic [15:0] br_count;
  logic [15:0] mp_count;

  always #5 clk = ~clk;

  branch_resolve_unit #(
    .DATA_W   (32),
    .OFFSET_W (16),
    .PHT_IDX_W(4),
    .CNT_W    (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .branch_op (branch_op),
    .pc_plus4  (pc_plus4),
    .offset    (offset),
    .gt        (gt),
    .lt        (lt),
    .et        (et),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .next_pc   (next_pc),
    .taken     (taken),
    .mispredict(mispredict),
    .illegal   (illegal),
    .br_count  (br_count),
    .mp_count  (mp_count)
  );

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  flags;  // {gt, lt, et}
    logic [31:0] pc;
    logic [15:0] off;
    logic        exp_taken;
    logic [31:0] exp_pc;
    logic        exp_ill;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Reference prediction state and statistics
  logic [1:0] m_pht [16];
  int         m_br;
  int         m_mp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_pht[i] = 2'b01;
    m_br = 0;
    m_mp = 0;
  endtask

  // Updates the model for one accepted branch and returns the expected mispredict.
  task automatic model_accept(input logic [2:0] op, input logic [31:0] pc, input logic t,
                              output logic exp_mp);
    logic [3:0] idx;
    idx    = pc[5:2];
    exp_mp = 1'b0;
    if (op[2] == 1'b0) begin
      exp_mp = (m_pht[idx][1] != t);
      if (t && m_pht[idx] != 2'd3) m_pht[idx] = m_pht[idx] + 2'd1;
      if (!t && m_pht[idx] != 2'd0) m_pht[idx] = m_pht[idx] - 2'd1;
      m_br++;
      if (exp_mp) m_mp++;
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [2:0] flags, input logic [31:0] pc,
                       input logic [15:0] off);
    branch_op = op;
    {gt, lt, et} = flags;
    pc_plus4 = pc;
    offset = off;
  endtask

  // One accept with out_ready=1, checked one cycle later.
  task automatic apply(input string tag, input vec_t v);
    logic exp_mp;
    drive(v.op, v.flags, v.pc, v.off);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    model_accept(v.op, v.pc, v.exp_taken, exp_mp);
    tick();
    in_valid = 1'b0;
    check({tag, ".out_valid"},  {31'd0, out_valid}, 32'd1);
    check({tag, ".next_pc"},    next_pc, v.exp_pc);
    check({tag, ".taken"},      {31'd0, taken}, {31'd0, v.exp_taken});
    check({tag, ".mispredict"}, {31'd0, mispredict}, {31'd0, exp_mp});
    check({tag, ".illegal"},    {31'd0, illegal}, {31'd0, v.exp_ill});
    check({tag, ".br_count"},   {16'd0, br_count}, m_br);
    check({tag, ".mp_count"},   {16'd0, mp_count}, m_mp);
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
  endtask

  vec_t       dir [10];
  vec_t       v;
  logic [7:0] masks [4];
  logic       mp_tmp;

  initial begin
    // op, flags{gt,lt,et}, pc, offset, taken, next_pc, illegal
    dir[0] = '{3'b011, 3'b001, 32'h0000_0300, 16'h0008, 1'b1, 32'h0000_0320, 1'b0};
    dir[1] = '{3'b010, 3'b000, 32'h0000_0300, 16'h0008, 1'b0, 32'h0000_0300, 1'b0};
    dir[2] = '{3'b000, 3'b001, 32'h0000_1000, 16'hFFFC, 1'b1, 32'h0000_0FF0, 1'b0};
    dir[3] = '{3'b100, 3'b000, 32'h0000_0000, 16'hFFFF, 1'b1, 32'hFFFF_FFFC, 1'b0};
    dir[4] = '{3'b100, 3'b000, 32'hFFFF_FFF0, 16'h0008, 1'b1, 32'h0000_0010, 1'b0};
    dir[5] = '{3'b110, 3'b111, 32'h0000_0200, 16'h0010, 1'b0, 32'h0000_0200, 1'b1};
    dir[6] = '{3'b101, 3'b001, 32'h0000_0204, 16'h0001, 1'b0, 32'h0000_0204, 1'b1};
    dir[7] = '{3'b111, 3'b111, 32'h0000_0208, 16'h0000, 1'b0, 32'h0000_0208, 1'b1};
    dir[8] = '{3'b010, 3'b100, 32'h7FFF_FFFC, 16'h7FFF, 1'b1, 32'h8001_FFF8, 1'b0};
    dir[9] = '{3'b001, 3'b110, 32'h0000_0040, 16'h8000, 1'b1, 32'hFFFE_0040, 1'b0};
    // Taken for each flag index {gt,lt,et}: beq, bne, bgt, ble
    masks[0] = 8'b1010_1010;
    masks[1] = 8'b0101_0101;
    masks[2] = 8'b1111_0000;
    masks[3] = 8'b1110_1110;

    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    drive(3'b000, 3'b000, 32'h0, 16'h0);
    model_reset();
    tick();
    tick();
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.next_pc", next_pc, 32'd0);
    check("rst.flags", {28'd0, taken, mispredict, illegal, in_ready}, 32'd1);
    check("rst.counts", {br_count, mp_count}, 32'd0);
    reset = 1'b1;
    idle();

    // beq taken at 0x100, four times, then bne not taken at the same index
    v = '{3'b000, 3'b001, 32'h0000_0100, 16'h0004, 1'b1, 32'h0000_0110, 1'b0};
    apply("beq1", v);
    check("beq1.mp_lit", {31'd0, mispredict}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      apply("beq_rep", v);
      check("beq_rep.mp_lit", {31'd0, mispredict}, 32'd0);
    end
    check("beq_rep.br_lit", {16'd0, br_count}, 32'd4);
    check("beq_rep.mp_cnt_lit", {16'd0, mp_count}, 32'd1);
    v = '{3'b001, 3'b001, 32'h0000_0100, 16'h0004, 1'b0, 32'h0000_0100, 1'b0};
    apply("bne", v);
    check("bne.mp_lit", {31'd0, mispredict}, 32'd1);
    check("bne.mp_cnt_lit", {16'd0, mp_count}, 32'd2);

    // Directed table
    for (int i = 0; i < 10; i++) apply($sformatf("dir%0d", i), dir[i]);

    // Flag decode: 4 conditional ops x 8 flag combinations
    for (int k = 0; k < 4; k++) begin
      for (int f = 0; f < 8; f++) begin
        v.op        = k[2:0];
        v.flags     = f[2:0];
        v.pc        = 32'h0000_0400;
        v.off       = 16'h0010;
        v.exp_taken = masks[k][f];
        v.exp_pc    = masks[k][f] ? 32'h0000_0440 : 32'h0000_0400;
        v.exp_ill   = 1'b0;
        apply($sformatf("flag_op%0d_f%0d", k, f), v);
      end
    end

    // Backpressure: A accepted, B held off for three stalled cycles
    idle();
    drive(3'b000, 3'b001, 32'h0000_0800, 16'h0001);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    model_accept(3'b000, 32'h0000_0800, 1'b1, mp_tmp);
    tick();
    check("bp.a_valid", {31'd0, out_valid}, 32'd1);
    check("bp.a_pc", next_pc, 32'h0000_0804);
    drive(3'b100, 3'b000, 32'h0000_0900, 16'h0002);
    for (int i = 0; i < 3; i++) begin
      check("bp.in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      check("bp.hold_pc", next_pc, 32'h0000_0804);
      check("bp.hold_valid", {31'd0, out_valid}, 32'd1);
    end
    check("bp.one_accept", {16'd0, br_count}, m_br);
    out_ready = 1'b1;
    #1;
    check("bp.release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("bp.b_pc", next_pc, 32'h0000_0908);
    drive(3'b100, 3'b000, 32'h0000_0A00, 16'h0003);
    tick();
    check("bp.c_pc", next_pc, 32'h0000_0A0C);
    check("bp.c_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    tick();
    check("bp.drain", {31'd0, out_valid}, 32'd0);

    // Flush with a pending result and a same-cycle input
    drive(3'b001, 3'b001, 32'h0000_0144, 16'h0004);  // bne, not taken
    in_valid  = 1'b1;
    out_ready = 1'b0;
    model_accept(3'b001, 32'h0000_0144, 1'b0, mp_tmp);
    tick();
    check("fl.pending", {31'd0, out_valid}, 32'd1);
    drive(3'b000, 3'b001, 32'h0000_0144, 16'h0004);  // beq taken, to be discarded
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl.killed", {31'd0, out_valid}, 32'd0);
    check("fl.br", {16'd0, br_count}, m_br);
    check("fl.mp", {16'd0, mp_count}, m_mp);
    v = '{3'b000, 3'b001, 32'h0000_0144, 16'h0004, 1'b1, 32'h0000_0154, 1'b0};
    apply("fl.after1", v);
    apply("fl.after2", v);

    // Reset mid-stream with an input present
    drive(3'b000, 3'b001, 32'h0000_0100, 16'h0004);
    in_valid = 1'b1;
    reset    = 1'b0;
    tick();
    check("mrst.out_valid", {31'd0, out_valid}, 32'd0);
    check("mrst.next_pc", next_pc, 32'd0);
    check("mrst.flags", {28'd0, taken, mispredict, illegal, in_ready}, 32'd1);
    check("mrst.counts", {br_count, mp_count}, 32'd0);
    reset    = 1'b1;
    in_valid = 1'b0;
    model_reset();
    v = '{3'b000, 3'b001, 32'h0000_0100, 16'h0004, 1'b1, 32'h0000_0110, 1'b0};
    apply("mrst.first", v);
    check("mrst.first_mp_lit", {31'd0, mispredict}, 32'd1);
    check("mrst.first_cnt_lit", {br_count, mp_count}, 32'h0001_0001);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Registered branch resolution stage for the 32-bit datapath, successor to the combinational branch selector. Accepts one branch per cycle from the decode/execute boundary and resolves beq/bne/bgt/ble/jump from the ALU compare flags. Computes the sign-extended, word-shifted target and returns the next PC with a valid/ready handshake. Keeps a per-index 2-bit saturating prediction table and statistics counters, and flags mispredictions to the fetch/flush logic.

## Interface

Parameters:
- DATA_W, 32, PC/target width.
- OFFSET_W, 16, immediate offset width (≤ DATA_W-2).
- PHT_IDX_W, 4, log2 of prediction-table entries (16 entries).
- CNT_W, 16, statistics counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low; sampled on the rising edge of clk.
- in_valid  in  1  branch request present.
- in_ready  out  1  unit can accept; equals !out_valid || out_ready.
- branch_op  in  3  000 beq, 001 bne, 010 bgt, 011 ble, 100 jump, 101–111 illegal.
- pc_plus4  in  DATA_W  PC of branch + 4.
- offset  in  OFFSET_W  signed word offset.
- gt, lt, et  in  1 each  ALU compare flags for this branch.
- flush  in  1  kill pending output and any same-cycle input.
- out_valid  out  1  result register holds a valid result.
- out_ready  in  1  consumer takes result.
- next_pc  out  DATA_W  resolved next PC.
- taken  out  1  resolved direction.
- mispredict  out  1  PHT prediction differed from resolved direction (conditional ops only).
- illegal  out  1  branch_op was 101–111.
- br_count  out  CNT_W  accepted conditional branches, saturating.
- mp_count  out  CNT_W  mispredicted conditional branches, saturating.

## Operation

- Accept: in_valid && in_ready && !flush at a rising edge.
- Condition: beq=et; bne=!et; bgt=gt; ble=lt|et; jump=1; illegal=0 with illegal=1.
- Target: pc_plus4 + (sign_extend(offset) << 2), truncated to DATA_W (wraps modulo 2^DATA_W).
- next_pc = taken ? target : pc_plus4.
- PHT index = pc_plus4[PHT_IDX_W+1:2]. Prediction = counter[1]. The counter is read combinationally at accept time.
- Conditional ops (000–011) on accept:
  - PHT update: taken → increment, saturating at 3; not taken → decrement, saturating at 0.
  - br_count increments.
  - mp_count increments when the prediction differs from the resolved direction.
  - Both counters saturate at all-ones.
- Jump and illegal ops: no PHT update, no counter change, mispredict=0.
- Output register: loaded on accept. Held stable while out_valid && !out_ready. Cleared (out_valid=0) on handshake without a new accept.
- flush: out_valid→0 at that edge. Same-cycle input is discarded, with no PHT update and no counter change. in_ready is not gated by flush.
- Simultaneous out handshake and accept: register reloads with the new result; out_valid stays 1.

## Timing

- Latency: 1 cycle, from accept edge N to result visible after edge N.
- Throughput: 1 branch/cycle while out_ready=1.
- Back-to-back branches on the same PHT index: the second lookup sees the first update (write at edge N, read before edge N+1).
- Reset (reset=0 at edge), including mid-operation, forces:
  - out_valid=0; next_pc, taken, mispredict, illegal = 0.
  - br_count = mp_count = 0.
  - All PHT entries = 2'b01 (weakly not taken).
  - in_ready=1 in the cycle after reset.
- Reset dominates flush and accept.

## Test plan

- Reset, then beq et=1, pc_plus4=0x00000100, offset=0x0004 → next cycle out_valid=1, next_pc=0x00000110, taken=1, mispredict=1, br_count=1, mp_count=1, PHT[0]=2.
- Repeat the same beq taken 3 more times → PHT[0] goes 2→3→3, mispredict=0 each time, br_count=4, mp_count=1. Then bne with et=1 at the same PC → taken=0, next_pc=0x00000100, mispredict=1, PHT[0]=2.
- Offset wrap: jump, pc_plus4=0x00000000, offset=0xFFFF → next_pc=0xFFFFFFFC, taken=1, mispredict=0, counters unchanged. Op 110 → taken=0, illegal=1, next_pc=pc_plus4.
- ble lt=0 et=1 → taken=1. bgt gt=0 → taken=0. Check flag decode for all 4 conditional ops × 8 flag combinations.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, outputs stable, exactly one accept. Release → one result per cycle thereafter.
- Flush with out_valid=1 and in_valid=1 → out_valid=0 next cycle, PHT and counters unchanged. Assert reset mid-stream → all outputs and counters 0, PHT entries read back as weakly not taken (first taken branch mispredicts).
